// File: rtl/affine_interp_mac_8.sv
// affine_interp_mac_8: sliding-window 16-phase interpolation filter, one multiply-accumulate per cycle
// Ports: clk/rst; in_valid/in_ready/in_sample/in_phase/in_sol sample stream;
//   out_valid/out_ready/out_data result stream; cfg_we/cfg_phase/cfg_tap/cfg_coef coefficient write, cfg_busy.
// Build option: AFFINE_INTERP_CLIP_EN clamps the rounded result to 0..255, otherwise it is passed signed.
module affine_interp_mac_8 #(
  parameter int TAPS = 8,
  parameter int CENTER = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_sample,
  input  logic [3:0]  in_phase,
  input  logic        in_sol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] out_data,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_phase,
  input  logic [2:0]  cfg_tap,
  input  logic [7:0]  cfg_coef,
  output logic        cfg_busy
);
  localparam int KW = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;
  logic [7:0] w [TAPS];
  logic signed [7:0] coef [16][TAPS];
  logic [3:0] cnt, cnt_nx, phase;
  logic [KW-1:0] k;
  logic signed [8:0] wx;
  logic signed [16:0] prod;
  logic signed [19:0] acc, acc_nx, rnd;
  logic signed [13:0] r, res;
  logic accept, fire, last;
  assign accept = in_valid && in_ready;
  assign cnt_nx = in_sol ? 4'd1 : cnt == 4'(TAPS) ? 4'(TAPS) : cnt + 4'd1;
  assign fire = accept && cnt_nx == 4'(TAPS);
  assign last = k == KW'(TAPS - 1);
  assign wx = $signed({1'b0, w[k]});
  assign prod = wx * coef[phase][k];
  assign acc_nx = acc + 20'(prod);
  assign rnd = acc_nx + 20'sd32;
  assign r = 14'(rnd >>> 6);
`ifdef AFFINE_INTERP_CLIP_EN
  assign res = r < 14'sd0 ? 14'sd0 : r > 14'sd255 ? 14'sd255 : r;
`else
  assign res = r;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (fire ? MAC : IDLE) :
               state == MAC  ? (last ? OUT : MAC) :
               (out_ready ? IDLE : OUT);
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == OUT;
    cfg_busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      k <= '0;
      phase <= '0;
      acc <= '0;
      out_data <= '0;
      for (int i = 0; i < TAPS; i++) w[i] <= '0;
      for (int p = 0; p < 16; p++)
        for (int i = 0; i < TAPS; i++)
          coef[p][i] <= (p == 0 && i == CENTER) ? 8'sd64 : 8'sd0;
    end else begin
      if (accept) begin
        cnt <= cnt_nx;
        for (int i = 0; i < TAPS - 1; i++) w[i] <= w[i+1];
        w[TAPS-1] <= in_sample;
      end
      if (cfg_we && state == IDLE && 32'(cfg_tap) < TAPS)
        coef[cfg_phase][cfg_tap[KW-1:0]] <= cfg_coef;
      if (fire) begin
        phase <= in_phase;
        acc <= '0;
        k <= '0;
      end
      if (state == MAC) begin
        acc <= acc_nx;
        k <= k + 1'b1;
        if (last) out_data <= res;
      end
    end
  end
endmodule

// File: tb/tb_affine_interp_mac_8.sv
// tb_affine_interp_mac_8: randomized and directed checks of affine_interp_mac_8 against an arithmetic model
module tb_affine_interp_mac_8;
  localparam int TAPS = 8;
  localparam int CENTER = 3;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_sol = 0;
  logic [7:0] in_sample = 0;
  logic [3:0] in_phase = 0;
  logic out_valid, out_ready = 1;
  logic [13:0] out_data;
  logic cfg_we = 0, cfg_busy;
  logic [3:0] cfg_phase = 0;
  logic [2:0] cfg_tap = 0;
  logic [7:0] cfg_coef = 0;
  int errs = 0, checks = 0;
  int cm [16][TAPS];
  int win [TAPS];
  int cnt;
  affine_interp_mac_8 #(.TAPS(TAPS), .CENTER(CENTER)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_phase(in_phase), .in_sol(in_sol),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_phase(cfg_phase), .cfg_tap(cfg_tap),
    .cfg_coef(cfg_coef), .cfg_busy(cfg_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void reset_model();
    for (int p = 0; p < 16; p++)
      for (int i = 0; i < TAPS; i++) cm[p][i] = 0;
    cm[0][CENTER] = 64;
    for (int i = 0; i < TAPS; i++) win[i] = 0;
    cnt = 0;
  endfunction
  function automatic int expect_out(input int ph);
    int sum, r;
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += cm[ph][i] * win[i];
    r = (sum + 32) >>> 6;
`ifdef AFFINE_INTERP_CLIP_EN
    r = r < 0 ? 0 : r > 255 ? 255 : r;
`endif
    return r;
  endfunction
  task automatic cfg_write(input int p, input int t, input int c);
    cfg_we = 1; cfg_phase = 4'(p); cfg_tap = 3'(t); cfg_coef = 8'(c);
    @(posedge clk); #1;
    cfg_we = 0;
    cm[p][t] = c;
  endtask
  task automatic send(input int s, input int ph, input bit sol);
    int n, e;
    in_valid = 1; in_sample = 8'(s); in_phase = 4'(ph); in_sol = sol;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_wait", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0; in_sol = 0;
    if (cfg_we) begin
      cm[cfg_phase][cfg_tap] = int'($signed(cfg_coef));
      cfg_we = 0;
    end
    if (sol) cnt = 0;
    for (int i = 0; i < TAPS - 1; i++) win[i] = win[i+1];
    win[TAPS-1] = s;
    cnt = cnt < TAPS ? cnt + 1 : TAPS;
    if (cnt == TAPS) begin
      e = expect_out(ph);
      n = 1;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("out_valid", int'(out_valid), 1);
      chk("latency", n, TAPS + 1);
      chk("out_data", int'($signed(out_data)), e);
      if (out_ready) begin @(posedge clk); #1; end
    end else begin
      chk("no_out_valid", int'(out_valid), 0);
      chk("still_ready", int'(in_ready), 1);
    end
  endtask
  initial begin
    int d;
    reset_model();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_cfg_busy", int'(cfg_busy), 0);
    for (int i = 0; i < 8; i++) send(10 + i, 0, i == 0);
    cfg_write(5, 3, 32);
    cfg_write(5, 4, 32);
    for (int i = 0; i < 8; i++) send(100 + i, 5, i == 0);
    cfg_write(7, 0, -128);
    for (int i = 0; i < 8; i++) send(255, 7, i == 0);
    cfg_write(7, 2, 127);
    cfg_we = 1; cfg_phase = 7; cfg_tap = 1; cfg_coef = 8'sd127;
    send(0, 7, 0);
    cfg_write(9, 0, 8);
    for (int i = 1; i < TAPS; i++) cfg_write(9, i, 8);
    for (int i = 0; i < 20; i++) send(i * 12, 9, 0);
    send(200, 9, 1);
    for (int i = 1; i < 8; i++) send(201 + i, 9, 0);
    for (int p = 1; p < 16; p++)
      for (int t = 0; t < TAPS; t++) cfg_write(p, t, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(int'($urandom_range(1, 15)), int'($urandom_range(0, TAPS - 1)),
                  int'($urandom_range(0, 255)) - 128);
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 8; i++) send(30 + i, 0, i == 0);
    out_ready = 0;
    send(50, 0, 0);
    d = int'(out_data);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin cfg_we = 1; cfg_phase = 0; cfg_tap = 3'(CENTER); cfg_coef = 0; end
      if (i == 6) cfg_we = 0;
      @(posedge clk); #1;
      chk("hold_data", int'(out_data), d);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_busy", int'(cfg_busy), 1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("released", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) send(60 + i, 0, i == 0);
    cfg_write(0, CENTER, 10);
    cfg_write(5, 0, 64);
    for (int i = 0; i < 7; i++) send(70 + i, 0, i == 0);
    in_valid = 1; in_sample = 77; in_phase = 0;
    @(posedge clk); #1;
    in_valid = 0;
    chk("mac_started", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    reset_model();
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(cfg_busy), 0);
    chk("abort_out_data", int'(out_data), 0);
    for (int i = 0; i < 8; i++) send(20 + i, 0, i == 0);
    for (int i = 0; i < 8; i++) send(120 + i, 5, i == 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
